sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 202 ++++++++++++++++++++
 tb/tb_sram_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// SRAM controller: bridges a single-word bus slave port to two external
// asynchronous SRAM chips (base and ext). Bit 22 of the byte address
// selects the chip. Every chip-side output is registered so the strobes
// never glitch. Address, byte enables and write data are held stable for
// the whole access.
module sram_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_address,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic [31:0] bus_data_wr,
  input  logic [3:0]  bus_mask,
  output logic        bus_stall,
  output logic [31:0] bus_data_rd,
  output logic [31:0] bus_data_rd_2,
  output logic [5:0]  bus_interrupt,
  output logic [19:0] base_addr,
  output logic [3:0]  base_be_n,
  output logic        base_ce_n,
  output logic        base_oe_n,
  output logic        base_we_n,
  input  logic [31:0] base_data_i,
  output logic [31:0] base_data_o,
  output logic        base_data_t,
  output logic [19:0] ext_addr,
  output logic [3:0]  ext_be_n,
  output logic        ext_ce_n,
  output logic        ext_oe_n,
  output logic        ext_we_n,
  input  logic [31:0] ext_data_i,
  output logic [31:0] ext_data_o,
  output logic        ext_data_t
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    WR_HOLD = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;        // 1 = ext chip, 0 = base chip
  logic [19:0] addr_q, addr_d;
  logic [3:0]  ben_q, ben_d;
  logic [31:0] wdata_q, wdata_d;
  logic        latch_en;

  // Chip-side output registers
  logic [19:0] base_addr_q, ext_addr_q;
  logic [3:0]  base_be_n_q, ext_be_n_q;
  logic        base_ce_n_q, base_oe_n_q, base_we_n_q, base_data_t_q;
  logic        ext_ce_n_q, ext_oe_n_q, ext_we_n_q, ext_data_t_q;
  logic [31:0] base_data_o_q, ext_data_o_q;
  logic [31:0] rd_data_q;

  // Decoded view of the next state, used to build registered strobes
  logic act_d, rd_d, we_d, drv_d;

  // Address bits outside [22] and [21:2] carry no meaning for this slave
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_address[31:23], bus_address[1:0]};

  // Next-state logic; the request is captured only when leaving IDLE so a
  // misbehaving master cannot disturb an access already in progress
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    ben_d    = ben_q;
    wdata_d  = wdata_q;
    latch_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_write) begin
          latch_en = 1'b1;
          state_d  = (bus_mask != 4'b0000) ? WR : DONE;
        end else if (bus_read) begin
          latch_en = 1'b1;
          state_d  = RD;
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: state_d = DONE;
      WR:      state_d = WR_HOLD;
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (latch_en) begin
      sel_d   = bus_address[22];
      addr_d  = bus_address[21:2];
      ben_d   = ~bus_mask;
      wdata_d = bus_data_wr;
    end
  end

  // Strobe decode from the state being entered, so the registers below
  // present the right levels during that state
  always_comb begin
    act_d = (state_d == RD) || (state_d == RD_WAIT) ||
            (state_d == WR) || (state_d == WR_HOLD);
    rd_d  = (state_d == RD) || (state_d == RD_WAIT);
    we_d  = (state_d == WR);
    drv_d = (state_d == WR) || (state_d == WR_HOLD);
  end

  // FSM state and latched request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      ben_q   <= 4'hF;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      ben_q   <= ben_d;
      wdata_q <= wdata_d;
    end
  end

  // Registered chip strobes; the unselected chip always stays idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_ce_n_q   <= 1'b1;
      base_oe_n_q   <= 1'b1;
      base_we_n_q   <= 1'b1;
      base_data_t_q <= 1'b1;
      base_be_n_q   <= 4'hF;
      ext_ce_n_q    <= 1'b1;
      ext_oe_n_q    <= 1'b1;
      ext_we_n_q    <= 1'b1;
      ext_data_t_q  <= 1'b1;
      ext_be_n_q    <= 4'hF;
    end else begin
      base_ce_n_q   <= ~(act_d & ~sel_d);
      base_oe_n_q   <= ~(rd_d  & ~sel_d);
      base_we_n_q   <= ~(we_d  & ~sel_d);
      base_data_t_q <= ~(drv_d & ~sel_d);
      base_be_n_q   <= (act_d & ~sel_d) ? ben_d : 4'hF;
      ext_ce_n_q    <= ~(act_d & sel_d);
      ext_oe_n_q    <= ~(rd_d  & sel_d);
      ext_we_n_q    <= ~(we_d  & sel_d);
      ext_data_t_q  <= ~(drv_d & sel_d);
      ext_be_n_q    <= (act_d & sel_d) ? ben_d : 4'hF;
    end
  end

  // Address and write data load once per access and then hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_addr_q   <= '0;
      ext_addr_q    <= '0;
      base_data_o_q <= '0;
      ext_data_o_q  <= '0;
    end else if (latch_en) begin
      if (sel_d) begin
        ext_addr_q   <= addr_d;
        ext_data_o_q <= wdata_d;
      end else begin
        base_addr_q   <= addr_d;
        base_data_o_q <= wdata_d;
      end
    end
  end

  // Read data captured at the end of RD_WAIT and held until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (state_q == RD_WAIT) begin
      rd_data_q <= sel_q ? ext_data_i : base_data_i;
    end
  end

  assign bus_stall     = (bus_read | bus_write) & (state_q != DONE);
  assign bus_data_rd   = rd_data_q;
  assign bus_data_rd_2 = '0;
  assign bus_interrupt = '0;

  assign base_addr   = base_addr_q;
  assign base_be_n   = base_be_n_q;
  assign base_ce_n   = base_ce_n_q;
  assign base_oe_n   = base_oe_n_q;
  assign base_we_n   = base_we_n_q;
  assign base_data_o = base_data_o_q;
  assign base_data_t = base_data_t_q;
  assign ext_addr    = ext_addr_q;
  assign ext_be_n    = ext_be_n_q;
  assign ext_ce_n    = ext_ce_n_q;
  assign ext_oe_n    = ext_oe_n_q;
  assign ext_we_n    = ext_we_n_q;
  assign ext_data_o  = ext_data_o_q;
  assign ext_data_t  = ext_data_t_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed table-driven bench for sram_controller.
module tb_sram_controller;

  logic        clk;
  logic        rst_n;
  logic [31:0] bus_address;
  logic        bus_read, bus_write;
  logic [31:0] bus_data_wr;
  logic [3:0]  bus_mask;
  logic        bus_stall;
  logic [31:0] bus_data_rd, bus_data_rd_2;
  logic [5:0]  bus_interrupt;
  logic [19:0] base_addr, ext_addr;
  logic [3:0]  base_be_n, ext_be_n;
  logic        base_ce_n, base_oe_n, base_we_n, base_data_t;
  logic        ext_ce_n, ext_oe_n, ext_we_n, ext_data_t;
  logic [31:0] base_data_i, ext_data_i, base_data_o, ext_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  sram_controller dut (
    .clk(clk), .rst_n(rst_n),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_data_wr(bus_data_wr), .bus_mask(bus_mask), .bus_stall(bus_stall),
    .bus_data_rd(bus_data_rd), .bus_data_rd_2(bus_data_rd_2),
    .bus_interrupt(bus_interrupt),
    .base_addr(base_addr), .base_be_n(base_be_n), .base_ce_n(base_ce_n),
    .base_oe_n(base_oe_n), .base_we_n(base_we_n), .base_data_i(base_data_i),
    .base_data_o(base_data_o), .base_data_t(base_data_t),
    .ext_addr(ext_addr), .ext_be_n(ext_be_n), .ext_ce_n(ext_ce_n),
    .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n), .ext_data_i(ext_data_i),
    .ext_data_o(ext_data_o), .ext_data_t(ext_data_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] chip_rdata;
    logic        exp_sel;     // 1 = ext
    int          exp_stall;
    int          exp_we;      // cycles with we_n low
    int          exp_oe;      // cycles with oe_n low
    int          exp_dt;      // cycles with data_t low
    logic [19:0] exp_addr;
    logic [3:0]  exp_ben;
    logic [31:0] exp_do;
    logic [31:0] exp_rd;      // bus_data_rd in DONE
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic chip_idle(input logic ce, oe, we, dt, input logic [3:0] ben);
    return ce && oe && we && dt && (ben == 4'hF);
  endfunction

  task automatic run_txn(input vec_t v);
    int stall_cnt = 0, we_cnt = 0, oe_cnt = 0, dt_cnt = 0, other_bad = 0;
    logic [19:0] cap_addr = '0;
    logic [3:0]  cap_ben  = 4'hF;
    logic [31:0] cap_do   = '0;
    logic        s_ce, s_oe, s_we, s_dt;
    @(negedge clk);
    bus_address = v.addr; bus_data_wr = v.wdata; bus_mask = v.mask;
    bus_write = v.wr; bus_read = v.rd;
    base_data_i = v.exp_sel ? ~v.chip_rdata : v.chip_rdata;
    ext_data_i  = v.exp_sel ? v.chip_rdata : ~v.chip_rdata;
    #1;
    while (bus_stall && stall_cnt < 10) begin
      stall_cnt++;
      @(posedge clk); #1;
      s_ce = v.exp_sel ? ext_ce_n : base_ce_n;
      s_oe = v.exp_sel ? ext_oe_n : base_oe_n;
      s_we = v.exp_sel ? ext_we_n : base_we_n;
      s_dt = v.exp_sel ? ext_data_t : base_data_t;
      if (!s_we) we_cnt++;
      if (!s_oe) oe_cnt++;
      if (!s_dt) dt_cnt++;
      if (!s_ce) begin
        cap_addr = v.exp_sel ? ext_addr : base_addr;
        cap_ben  = v.exp_sel ? ext_be_n : base_be_n;
        cap_do   = v.exp_sel ? ext_data_o : base_data_o;
      end
      if (v.exp_sel ? !chip_idle(base_ce_n, base_oe_n, base_we_n, base_data_t, base_be_n)
                    : !chip_idle(ext_ce_n, ext_oe_n, ext_we_n, ext_data_t, ext_be_n))
        other_bad++;
    end
    chk({v.name, " stall"}, stall_cnt, v.exp_stall);
    chk({v.name, " we"}, we_cnt, v.exp_we);
    chk({v.name, " oe"}, oe_cnt, v.exp_oe);
    chk({v.name, " data_t"}, dt_cnt, v.exp_dt);
    chk({v.name, " other_chip"}, other_bad, 0);
    chk({v.name, " rd_data"}, bus_data_rd, v.exp_rd);
    if (v.exp_stall > 1) begin
      chk({v.name, " addr"}, {12'h0, cap_addr}, {12'h0, v.exp_addr});
      chk({v.name, " be_n"}, {28'h0, cap_ben}, {28'h0, v.exp_ben});
    end
    if (v.exp_we > 0) chk({v.name, " data_o"}, cap_do, v.exp_do);
    bus_read = 1'b0; bus_write = 1'b0;
    @(posedge clk); #1;
    chk({v.name, " idle_after"},
        {31'h0, chip_idle(base_ce_n, base_oe_n, base_we_n, base_data_t, base_be_n) &&
                chip_idle(ext_ce_n, ext_oe_n, ext_we_n, ext_data_t, ext_be_n)}, 32'h1);
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    //          name        wr rd addr          wdata         mask     chip_rd       sel st we oe dt addr       ben      data_o        rd
    vecs[0] = '{"base_wr",  1, 0, 32'h0000_0010, 32'hDEADBEEF, 4'b1111, 32'h0,        0, 3, 1, 0, 2, 20'h00004, 4'b0000, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{"ext_rd",   0, 1, 32'h0040_0008, 32'h0,        4'b1111, 32'h12345678, 1, 3, 0, 2, 0, 20'h00002, 4'b0000, 32'h0,        32'h12345678};
    vecs[2] = '{"byte_wr",  1, 0, 32'h0000_0104, 32'hA5A55A5A, 4'b0100, 32'h0,        0, 3, 1, 0, 2, 20'h00041, 4'b1011, 32'hA5A55A5A, 32'h12345678};
    vecs[3] = '{"rdwr",     1, 1, 32'h0040_1000, 32'h11223344, 4'b0011, 32'h0,        1, 3, 1, 0, 2, 20'h00400, 4'b1100, 32'h11223344, 32'h12345678};
    vecs[4] = '{"mask0",    1, 0, 32'h0000_0020, 32'h99999999, 4'b0000, 32'h0,        0, 1, 0, 0, 0, 20'h0,     4'hF,    32'h0,        32'h12345678};
    vecs[5] = '{"base_rd",  0, 1, 32'h0000_FFFC, 32'h0,        4'b1111, 32'hCAFEF00D, 0, 3, 0, 2, 0, 20'h03FFF, 4'b0000, 32'h0,        32'hCAFEF00D};
    vecs[6] = '{"ext_hi",   0, 1, 32'hFF7F_FFFF, 32'h0,        4'b1111, 32'h0BADCAFE, 1, 3, 0, 2, 0, 20'hFFFFF, 4'b0000, 32'h0,        32'h0BADCAFE};

    rst_n = 1'b0; bus_address = '0; bus_read = 0; bus_write = 0;
    bus_data_wr = '0; bus_mask = '0; base_data_i = '0; ext_data_i = '0;
    #22;
    chk("rst strobes", {31'h0, chip_idle(base_ce_n, base_oe_n, base_we_n, base_data_t, base_be_n) &&
                               chip_idle(ext_ce_n, ext_oe_n, ext_we_n, ext_data_t, ext_be_n)}, 32'h1);
    chk("rst addr", {base_addr, ext_addr[11:0]}, 32'h0);
    chk("rst data_o", base_data_o | ext_data_o, 32'h0);
    chk("rst rd_data", bus_data_rd, 32'h0);
    chk("rst stall", {31'h0, bus_stall}, 32'h0);
    chk("rd2_irq", bus_data_rd_2 | {26'h0, bus_interrupt}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset asserted while the ext chip is in WR
    @(negedge clk);
    bus_address = 32'h0040_0004; bus_data_wr = 32'hFEEDFACE;
    bus_mask = 4'hF; bus_write = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst we_n", {31'h0, ext_we_n}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("async we_n", {31'h0, ext_we_n}, 32'h1);
    chk("async ce_n", {31'h0, ext_ce_n}, 32'h1);
    chk("async data_t", {31'h0, ext_data_t}, 32'h1);
    chk("async rd_data", bus_data_rd, 32'h0);
    bus_write = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rv = '{"post_rst_rd", 0, 1, 32'h0000_0008, 32'h0, 4'b1111, 32'h55AA55AA,
           0, 3, 0, 2, 0, 20'h00002, 4'b0000, 32'h0, 32'h55AA55AA};
    run_txn(rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
